// File: rtl/clock_time_ctrl.sv
// rtl/clock_time_ctrl.sv - 24-hour time-of-day counter with two-button set mode
// Buttons are synchronized and edge-detected; all outputs come straight from flops.
module clock_time_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       blink,
  output logic       day_pulse
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } mode_e;

  logic [SYNC_STAGES-1:0] mode_sync_q;
  logic [SYNC_STAGES-1:0] inc_sync_q;
  logic                   mode_hist_q;
  logic                   inc_hist_q;

  mode_e      state_q;
  logic [4:0] hours_q;
  logic [5:0] minutes_q;
  logic [5:0] seconds_q;
  logic       blink_q;
  logic       day_pulse_q;

  logic mode_press;
  logic inc_press;
  logic sec_max;
  logic min_max;
  logic hr_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_sync_q <= '0;
      inc_sync_q  <= '0;
      mode_hist_q <= 1'b0;
      inc_hist_q  <= 1'b0;
    end else begin
      mode_sync_q <= {mode_sync_q[SYNC_STAGES-2:0], btn_mode};
      inc_sync_q  <= {inc_sync_q[SYNC_STAGES-2:0], btn_inc};
      mode_hist_q <= mode_sync_q[SYNC_STAGES-1];
      inc_hist_q  <= inc_sync_q[SYNC_STAGES-1];
    end
  end

  assign mode_press = mode_sync_q[SYNC_STAGES-1] & ~mode_hist_q;
  assign inc_press  = inc_sync_q[SYNC_STAGES-1] & ~inc_hist_q;

  assign sec_max = (seconds_q == 6'd59);
  assign min_max = (minutes_q == 6'd59);
  assign hr_max  = (hours_q == 5'd23);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      hours_q     <= 5'd0;
      minutes_q   <= 6'd0;
      seconds_q   <= 6'd0;
      blink_q     <= 1'b0;
      day_pulse_q <= 1'b0;
    end else begin
      day_pulse_q <= 1'b0;
      case (state_q)
        RUN: begin
          blink_q <= 1'b0;
          if (mode_press) begin
            state_q <= SET_HR;
          end
          // Whole carry chain resolves in one edge so the display never shows a half-carried time.
          if (tick_1hz) begin
            if (!sec_max) begin
              seconds_q <= seconds_q + 6'd1;
            end else begin
              seconds_q <= 6'd0;
              if (!min_max) begin
                minutes_q <= minutes_q + 6'd1;
              end else begin
                minutes_q <= 6'd0;
                if (!hr_max) begin
                  hours_q <= hours_q + 5'd1;
                end else begin
                  hours_q     <= 5'd0;
                  day_pulse_q <= 1'b1;
                end
              end
            end
          end
        end
        SET_HR: begin
          if (mode_press) begin
            state_q <= SET_MIN;
            blink_q <= 1'b0;
          end else if (inc_press) begin
            hours_q <= hr_max ? 5'd0 : hours_q + 5'd1;
            blink_q <= 1'b0;
          end else if (tick_1hz) begin
            blink_q <= ~blink_q;
          end
        end
        SET_MIN: begin
          if (mode_press) begin
            state_q   <= RUN;
            seconds_q <= 6'd0;
            blink_q   <= 1'b0;
          end else if (inc_press) begin
            minutes_q <= min_max ? 6'd0 : minutes_q + 6'd1;
            blink_q   <= 1'b0;
          end else if (tick_1hz) begin
            blink_q <= ~blink_q;
          end
        end
        default: begin
          state_q <= RUN;
          blink_q <= 1'b0;
        end
      endcase

      // Corrupted fields snap back to zero rather than counting through illegal values.
      if (hours_q > 5'd23) begin
        hours_q <= 5'd0;
      end
      if (minutes_q > 6'd59) begin
        minutes_q <= 6'd0;
      end
      if (seconds_q > 6'd59) begin
        seconds_q <= 6'd0;
      end
    end
  end

  assign hours     = hours_q;
  assign minutes   = minutes_q;
  assign seconds   = seconds_q;
  assign mode      = state_q;
  assign blink     = blink_q;
  assign day_pulse = day_pulse_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb/tb_clock_time_ctrl.sv - directed self-checking bench for clock_time_ctrl
// Expected values are hand-computed and tracked through the scenario sequence.
module tb_clock_time_ctrl;

  logic       clk;
  logic       rst_n;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       blink;
  logic       day_pulse;

  int vectors;
  int miscompares;

  clock_time_ctrl #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1hz  (tick_1hz),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .hours     (hours),
    .minutes   (minutes),
    .seconds   (seconds),
    .mode      (mode),
    .blink     (blink),
    .day_pulse (day_pulse)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic press_mode();
    @(negedge clk) btn_mode = 1'b1;
    repeat (4) @(negedge clk);
    btn_mode = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) btn_inc = 1'b1;
      repeat (4) @(negedge clk);
      btn_inc = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick_1hz = 1'b1;
      @(negedge clk) tick_1hz = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_mode = 1'b1;
    #20;
    vectors++;
    if ({hours, minutes, seconds, mode, blink, day_pulse} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", {hours, minutes, seconds, mode, blink, day_pulse});
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (mode !== 2'b01) begin
      miscompares++;
      $display("FAIL held_button_after_reset: mode got %b want 01", mode);
    end
    btn_mode = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (mode !== 2'b01) begin
      miscompares++;
      $display("FAIL held_button_single_press: mode got %b want 01", mode);
    end
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_set_flow();
    press_mode();
    press_inc(5);
    press_mode();
    press_inc(20);
    press_mode();
    tick(44);
    vectors++;
    if ({hours, minutes, seconds, mode} !== {5'd5, 6'd20, 6'd44, 2'b00}) begin
      miscompares++;
      $display("FAIL set_flow_start: got %0d:%0d:%0d m%b want 5:20:44 m00", hours, minutes, seconds, mode);
    end
    press_mode();
    press_inc(3);
    tick(2);
    vectors++;
    if ({hours, minutes, seconds, mode} !== {5'd8, 6'd20, 6'd44, 2'b01}) begin
      miscompares++;
      $display("FAIL set_flow_hr: got %0d:%0d:%0d m%b want 8:20:44 m01", hours, minutes, seconds, mode);
    end
    press_mode();
    press_inc(45);
    tick(3);
    vectors++;
    if ({hours, minutes, seconds, mode} !== {5'd8, 6'd5, 6'd44, 2'b10}) begin
      miscompares++;
      $display("FAIL set_flow_min: got %0d:%0d:%0d m%b want 8:5:44 m10", hours, minutes, seconds, mode);
    end
    press_mode();
    vectors++;
    if ({hours, minutes, seconds, mode} !== {5'd8, 6'd5, 6'd0, 2'b00}) begin
      miscompares++;
      $display("FAIL set_flow_end: got %0d:%0d:%0d m%b want 8:5:0 m00", hours, minutes, seconds, mode);
    end
  endtask

  task automatic test_wrap_set();
    press_mode();
    press_inc(15);
    vectors++;
    if (hours !== 5'd23) begin
      miscompares++;
      $display("FAIL wrap_hr_pre: hours got %0d want 23", hours);
    end
    press_inc(1);
    vectors++;
    if ({hours, minutes} !== {5'd0, 6'd5}) begin
      miscompares++;
      $display("FAIL wrap_hr: got %0d:%0d want 0:5", hours, minutes);
    end
    press_mode();
    press_inc(54);
    vectors++;
    if (minutes !== 6'd59) begin
      miscompares++;
      $display("FAIL wrap_min_pre: minutes got %0d want 59", minutes);
    end
    press_inc(1);
    vectors++;
    if ({hours, minutes, day_pulse} !== {5'd0, 6'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL wrap_min: got %0d:%0d dp%b want 0:0 dp0", hours, minutes, day_pulse);
    end
    press_mode();
  endtask

  task automatic test_rollover();
    press_mode();
    press_inc(23);
    press_mode();
    press_inc(59);
    press_mode();
    tick(59);
    vectors++;
    if ({hours, minutes, seconds, day_pulse} !== {5'd23, 6'd59, 6'd59, 1'b0}) begin
      miscompares++;
      $display("FAIL rollover_pre: got %0d:%0d:%0d dp%b want 23:59:59 dp0", hours, minutes, seconds, day_pulse);
    end
    tick(1);
    vectors++;
    if ({hours, minutes, seconds, day_pulse} !== {5'd0, 6'd0, 6'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL rollover: got %0d:%0d:%0d dp%b want 0:0:0 dp1", hours, minutes, seconds, day_pulse);
    end
    @(negedge clk);
    vectors++;
    if (day_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL day_pulse_width: got %b want 0", day_pulse);
    end
  endtask

  task automatic test_minute_carry();
    press_mode();
    press_inc(10);
    press_mode();
    press_inc(59);
    press_mode();
    tick(59);
    tick(1);
    vectors++;
    if ({hours, minutes, seconds, day_pulse} !== {5'd11, 6'd0, 6'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL minute_carry: got %0d:%0d:%0d dp%b want 11:0:0 dp0", hours, minutes, seconds, day_pulse);
    end
    tick(31);
    vectors++;
    if ({hours, minutes, seconds} !== {5'd11, 6'd0, 6'd31}) begin
      miscompares++;
      $display("FAIL seconds_only: got %0d:%0d:%0d want 11:0:31", hours, minutes, seconds);
    end
  endtask

  task automatic test_blink();
    vectors++;
    if (blink !== 1'b0) begin
      miscompares++;
      $display("FAIL blink_run: got %b want 0", blink);
    end
    press_mode();
    tick(3);
    vectors++;
    if (blink !== 1'b1) begin
      miscompares++;
      $display("FAIL blink_toggle: got %b want 1", blink);
    end
    press_inc(1);
    vectors++;
    if ({blink, hours} !== {1'b0, 5'd12}) begin
      miscompares++;
      $display("FAIL blink_inc: blink %b hours %0d want 0 12", blink, hours);
    end
    tick(1);
    press_mode();
    vectors++;
    if ({blink, mode, seconds} !== {1'b0, 2'b10, 6'd31}) begin
      miscompares++;
      $display("FAIL blink_mode: blink %b mode %b sec %0d want 0 10 31", blink, mode, seconds);
    end
    press_mode();
  endtask

  task automatic test_press_timing();
    press_mode();
    press_mode();
    @(negedge clk) btn_inc = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (minutes !== 6'd0) begin
      miscompares++;
      $display("FAIL press_early: minutes got %0d want 0", minutes);
    end
    @(negedge clk);
    vectors++;
    if (minutes !== 6'd1) begin
      miscompares++;
      $display("FAIL press_edge3: minutes got %0d want 1", minutes);
    end
    repeat (1000) @(negedge clk);
    vectors++;
    if (minutes !== 6'd1) begin
      miscompares++;
      $display("FAIL press_hold: minutes got %0d want 1", minutes);
    end
    btn_inc = 1'b0;
    repeat (4) @(negedge clk);
    press_mode();
    press_mode();
    @(negedge clk) begin
      btn_mode = 1'b1;
      btn_inc  = 1'b1;
    end
    repeat (4) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if ({mode, hours, minutes} !== {2'b10, 5'd12, 6'd1}) begin
      miscompares++;
      $display("FAIL mode_over_inc: got m%b %0d:%0d want m10 12:1", mode, hours, minutes);
    end
  endtask

  task automatic test_reset_mid_edit();
    press_mode();
    press_mode();
    press_inc(2);
    press_mode();
    press_inc(32);
    tick(1);
    vectors++;
    if ({mode, hours, minutes, blink} !== {2'b10, 5'd14, 6'd33, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_edit_pre: got m%b %0d:%0d b%b want m10 14:33 b1", mode, hours, minutes, blink);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({hours, minutes, seconds, mode, blink, day_pulse} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_mid_edit: got %h want 0", {hours, minutes, seconds, mode, blink, day_pulse});
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    tick_1hz    = 1'b0;
    btn_inc     = 1'b0;
    btn_mode    = 1'b0;
    rst_n       = 1'b0;
    test_reset();
    test_set_flow();
    test_wrap_set();
    test_rollover();
    test_minute_carry();
    test_blink();
    test_press_timing();
    test_reset_mid_edit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/clock_time_ctrl.md
CLOCK_TIME_CTRL -- requirements
Module: clock_time_ctrl

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of button synchronizer flops; legal values are 2 to 4.
REQ-002 Port: clk  input  1  system clock (125 MHz); all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: tick_1hz  input  1  one-clk-cycle enable pulse, once per second, synchronous to clk.
REQ-005 Port: btn_mode  input  1  raw debounced mode button level, asynchronous to clk.
REQ-006 Port: btn_inc  input  1  raw debounced increment button level, asynchronous to clk.
REQ-007 Port: hours  output  5  current hour, binary, range 0-23.
REQ-008 Port: minutes  output  6  current minute, binary, range 0-59.
REQ-009 Port: seconds  output  6  current second, binary, range 0-59.
REQ-010 Port: mode  output  2  FSM state: 00 RUN, 01 SET_HR, 10 SET_MIN; 11 is never driven.
REQ-011 Port: blink  output  1  display blank-phase flag for the field being edited.
REQ-012 Port: day_pulse  output  1  one-cycle pulse on rollover from 23:59:59 to 00:00:00.

Function
REQ-013 Each button SHALL pass through a SYNC_STAGES-flop synchronizer, followed by one history flop.
REQ-014 A button press SHALL be the rising edge of the synchronized level, detected as (sync_last AND NOT history).
REQ-015 The effect of a press SHALL appear on outputs at rising edge SYNC_STAGES+1 after the first edge that samples the button high (3rd edge at default).
REQ-016 Holding a button high SHALL produce exactly one press; a release is required before the next press.
REQ-017 FSM transitions on a mode press SHALL be RUN->SET_HR, SET_HR->SET_MIN and SET_MIN->RUN.
REQ-018 On SET_MIN->RUN, seconds SHALL be cleared to 0 on the same edge.
REQ-019 In RUN, when tick_1hz=1, seconds SHALL increment by 1.
REQ-020 In RUN, seconds 59 SHALL wrap to 0 and carry into minutes.
REQ-021 In RUN, minutes 59 with a carry SHALL wrap to 0 and carry into hours.
REQ-022 In RUN, hours 23 with a carry SHALL wrap to 0.
REQ-023 All RUN time fields SHALL update on the same edge (no ripple cycles).
REQ-024 day_pulse SHALL be 1 for exactly the cycle following the edge on which the time becomes 00:00:00 via the tick carry chain.
REQ-025 day_pulse SHALL never assert due to a set-mode edit.
REQ-026 In SET_HR or SET_MIN, tick_1hz SHALL NOT advance the time; seconds hold.
REQ-027 In SET_HR, an inc press SHALL increment hours modulo 24 (23->0), with no carry and no other field change.
REQ-028 In SET_MIN, an inc press SHALL increment minutes modulo 60 (59->0), with no carry into hours.
REQ-029 In RUN, an inc press SHALL be ignored.
REQ-030 When a mode press and an inc press occur in the same cycle, mode SHALL take effect and inc SHALL be discarded.
REQ-031 blink SHALL be 0 in RUN.
REQ-032 In SET states, blink SHALL toggle on each tick_1hz.
REQ-033 blink SHALL be forced to 0 on any mode transition and on any inc press, so the edited value is visible immediately.
REQ-034 Time fields SHALL never hold out-of-range values; any out-of-range state SHALL be corrected to 0 on the next edge.
REQ-035 The FSM SHALL recover to RUN from the illegal state 11 on the next edge.
REQ-036 All outputs SHALL be registered; no combinational path SHALL exist from any input to any output.

Reset
REQ-037 While rst_n=0, all outputs SHALL be held asynchronously at: hours=0, minutes=0, seconds=0, mode=00, blink=0, day_pulse=0.
REQ-038 While rst_n=0, all synchronizer and history flops SHALL be held at 0.
REQ-039 After rst_n deasserts, a button already held high SHALL register as one press.
REQ-040 An rst_n assertion during SET_HR or SET_MIN SHALL abort the edit and return to RUN at 00:00:00.

Verification
REQ-041 Rollover: load 23:59:59 in RUN, apply one tick_1hz -> next edge shows 00:00:00, day_pulse high for 1 cycle only.
REQ-042 Minute carry: RUN at 10:59:59, tick -> 11:00:00, day_pulse=0; tick with seconds=30 -> seconds=31 only.
REQ-043 Set flow: RUN 05:20:44; press mode, inc x3, mode, inc x45, mode -> 08:05:00, mode=00; ticks during edit leave time unchanged.
REQ-044 Wrap in set: SET_HR at hours=23, inc -> hours=0, minutes unchanged; SET_MIN at 59, inc -> 0, hours unchanged.
REQ-045 Press timing: btn_inc held for 1000 cycles in SET_MIN -> exactly one increment, at the 3rd sampling edge; mode and inc rising together -> mode advances, no increment.
REQ-046 Reset mid-edit: in SET_MIN at 14:33, pulse rst_n low asynchronously between clk edges -> outputs immediately 00:00:00, mode=00, blink=0.
